// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, models mult/div latency, raises stall_md.
// Optional MDU_CANCEL_EN: a flush (req) while busy aborts the in-flight operation without commit.
module e_mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDOp,
    input  logic        MDWE,
    input  logic        MDAddrOp,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        req,
    input  logic        d_md,
    output logic [31:0] md_out,
    output logic        busy,
    output logic        stall_md
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_ok;

    logic        w_op_valid;
    logic        w_is_div;
    logic        w_start;
    logic        w_b_zero;
    logic [31:0] w_div_b;
    logic [63:0] w_uprod;
    logic [63:0] w_sprod;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_op_valid = (MDOp >= 3'd1) && (MDOp <= 3'd4);
    assign w_is_div   = (MDOp == 3'd3) || (MDOp == 3'd4);
    assign w_start    = w_op_valid && !req && (r_state == S_IDLE);

    assign busy     = (r_state == S_BUSY);
    assign stall_md = d_md && (busy || w_start);
    assign md_out   = MDAddrOp ? r_hi : r_lo;

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_uprod = {32'd0, rs_data} * {32'd0, rt_data};
    assign w_sprod = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};

    // Divisor 0 is replaced by 1 only to keep the divider defined; that result is never committed.
    assign w_b_zero = (rt_data == 32'd0);
    assign w_div_b  = w_b_zero ? 32'd1 : rt_data;
    assign w_uq     = rs_data / w_div_b;
    assign w_ur     = rs_data % w_div_b;

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
    assign w_a_mag = rs_data[31] ? (32'd0 - rs_data) : rs_data;
    assign w_b_mag = rt_data[31] ? (32'd0 - rt_data) : w_div_b;
    assign w_mag_q = w_a_mag / w_b_mag;
    assign w_mag_r = w_a_mag % w_b_mag;
    assign w_sq    = (rs_data[31] ^ rt_data[31]) ? (32'd0 - w_mag_q) : w_mag_q;
    assign w_sr    = rs_data[31] ? (32'd0 - w_mag_r) : w_mag_r;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (MDOp)
            3'd1: begin
                w_res_hi = w_uprod[63:32];
                w_res_lo = w_uprod[31:0];
            end
            3'd2: begin
                w_res_hi = w_sprod[63:32];
                w_res_lo = w_sprod[31:0];
            end
            3'd3: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
            end
            3'd4: begin
                w_res_hi = w_sr;
                w_res_lo = w_sq;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_ok <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_ok <= !(w_is_div && w_b_zero);
                        r_cnt     <= w_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        r_state   <= S_BUSY;
                    end else if (MDWE && !req) begin
                        if (MDAddrOp) begin
                            r_hi <= rs_data;
                        end else begin
                            r_lo <= rs_data;
                        end
                    end
                end
                S_BUSY: begin
`ifdef MDU_CANCEL_EN
                    if (req) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else
`endif
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_pend_ok) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them against md_out, busy and stall_md.
module tb_e_mdu_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  MDOp = 3'd0;
    logic        MDWE = 1'b0;
    logic        MDAddrOp = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        req = 1'b0;
    logic        d_md = 1'b0;
    logic [31:0] md_out;
    logic        busy;
    logic        stall_md;

    typedef struct {
        logic [31:0] md;
        logic        busy;
        logic        stall;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount = 0;
    int   cycleNo = 0;

    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    logic [31:0] mPendHi = 32'd0;
    logic [31:0] mPendLo = 32'd0;
    bit          mPendOk = 1'b0;
    int          mRem = 0;

    e_mdu_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .MDOp    (MDOp),
        .MDWE    (MDWE),
        .MDAddrOp(MDAddrOp),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .req     (req),
        .d_md    (d_md),
        .md_out  (md_out),
        .busy    (busy),
        .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int cyc,
                               input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Arithmetic reference using 64-bit integers; ok=0 marks a divide by zero (no commit).
    task automatic refCompute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo, output bit ok);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ok = 1'b1;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            3'd1: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin q = sa * sb; hi = q[63:32]; lo = q[31:0]; end
            3'd3: begin
                if (b == 32'd0) ok = 1'b0;
                else begin p = ua / ub; lo = p[31:0]; p = ua % ub; hi = p[31:0]; end
            end
            3'd4: begin
                if (b == 32'd0) ok = 1'b0;
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: ok = 1'b0;
        endcase
    endtask

    task automatic applyStimulus(input bit rst, input logic [2:0] op, input bit we, input bit addr,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit rq, input bit dm);
        exp_t e;
        bit   isOp, start;
        @(posedge clk);
        #1;
        reset    = rst;
        MDOp     = op;
        MDWE     = we;
        MDAddrOp = addr;
        rs_data  = a;
        rt_data  = b;
        req      = rq;
        d_md     = dm;
        cycleNo++;
        if (!rst) begin
            mHi  = 32'd0;
            mLo  = 32'd0;
            mRem = 0;
        end
        isOp    = (op >= 3'd1) && (op <= 3'd4);
        start   = isOp && !rq && (mRem == 0);
        e.md    = addr ? mHi : mLo;
        e.busy  = (mRem > 0);
        e.stall = dm && ((mRem > 0) || start);
        e.cyc   = cycleNo;
        expQ.push_back(e);
        if (rst) begin
            if (mRem > 0) begin
`ifdef MDU_CANCEL_EN
                if (rq) mRem = 0;
                else
`endif
                if (mRem == 1) begin
                    if (mPendOk) begin
                        mHi = mPendHi;
                        mLo = mPendLo;
                    end
                    mRem = 0;
                end else begin
                    mRem--;
                end
            end else if (start) begin
                refCompute(op, a, b, mPendHi, mPendLo, mPendOk);
                mRem = (op >= 3'd3) ? DIV_LAT : MULT_LAT;
            end else if (we && !rq) begin
                if (addr) mHi = a;
                else      mLo = a;
            end
        end
    endtask

    task automatic runIdle(input int n, input bit addr, input bit dm);
        repeat (n) applyStimulus(1'b1, 3'd0, 1'b0, addr, 32'd0, 32'd0, 1'b0, dm);
    endtask

    task automatic readHiLo();
        runIdle(1, 1'b1, 1'b0);
        runIdle(1, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("md_out", e.cyc, md_out, e.md);
                checkOutput("busy", e.cyc, {31'd0, busy}, {31'd0, e.busy});
                checkOutput("stall_md", e.cyc, {31'd0, stall_md}, {31'd0, e.stall});
            end
        end
    end

    initial begin
        logic [2:0]  rOp;
        logic [31:0] rA, rB;

        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);

        // mult with a D-stage MDU instruction waiting from the start cycle
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
        runIdle(MULT_LAT + 1, 1'b1, 1'b1);
        readHiLo();
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        runIdle(MULT_LAT + 1, 1'b0, 1'b0);
        readHiLo();

        applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        runIdle(DIV_LAT + 1, 1'b1, 1'b0);
        readHiLo();
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
        runIdle(DIV_LAT + 1, 1'b0, 1'b0);
        readHiLo();

        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        runIdle(1, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0);
        runIdle(1, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 32'h0BAD_BEEF, 32'd0, 1'b0, 1'b0);
        runIdle(1, 1'b0, 1'b0);

        // flush in the third busy cycle of a divide
        applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
        runIdle(2, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        runIdle(DIV_LAT, 1'b0, 1'b0);
        readHiLo();

        // writes and new ops while busy have no effect
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 32'd7, 32'd6, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 32'hDEAD_DEAD, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 32'd9, 32'd3, 1'b0, 1'b0);
        runIdle(MULT_LAT, 1'b1, 1'b0);
        readHiLo();
        applyStimulus(1'b1, 3'd1, 1'b1, 1'b1, 32'h10, 32'h20, 1'b0, 1'b0);
        runIdle(MULT_LAT + 1, 1'b1, 1'b0);
        readHiLo();

        applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        runIdle(DIV_LAT + 1, 1'b0, 1'b0);
        readHiLo();

        // reset asserted mid-mult, then a fresh mult
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 32'd3, 32'd4, 1'b0, 1'b0);
        runIdle(2, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 32'h11, 32'h22, 1'b0, 1'b1);
        runIdle(MULT_LAT + 1, 1'b0, 1'b1);
        readHiLo();

        for (int i = 0; i < 400; i++) begin
            rOp = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            rA  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rB = 32'd0;
                1:       rB = 32'hFFFF_FFFF;
                2:       rB = 32'($urandom_range(1, 15));
                default: rB = $urandom;
            endcase
            applyStimulus(1'b1, rOp, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                          rA, rB, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end

        runIdle(DIV_LAT + 1, 1'b0, 1'b0);
        readHiLo();
        repeat (2) @(posedge clk);
        checkOutput("queue_drained", cycleNo, 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
